// File: rtl/tx_pkg.sv
// Shared types and constants for the tx_engine PAUSE enforcement block.
package tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XMIT   = 2'd1,
        ST_PAUSED = 2'd2
    } tx_state_e;

    localparam int DEFAULT_QUANTA_W   = 16;
    localparam int PAUSE_QUANTUM_BITS = 512;

    // Clocks per pause quantum for a datapath moving datapath_w bits per clock.
    function automatic int cycles_per_quanta(input int datapath_w);
        return PAUSE_QUANTUM_BITS / datapath_w;
    endfunction

endpackage

// File: rtl/tx_pause_ctrl_prescaler.sv
// quanta_prescaler: free-running 0..CYCLES_PER_QUANTA-1 counter that strobes
// o_wrap on its last count; i_clear has priority over i_enable.
module quanta_prescaler #(
    parameter int CYCLES_PER_QUANTA = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_wrap
);

    localparam int CNT_W = $clog2(CYCLES_PER_QUANTA);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_QUANTA - 1);

    logic [CNT_W-1:0] r_count;

    assign o_wrap = i_enable && (r_count == LAST);

    // Power-of-two period, so the natural binary rollover is the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tx_pause_ctrl.sv
// tx_pause_ctrl: gates frame-start grants while an 802.3x PAUSE is in force.
// Optional `TX_PAUSE_STATS_EN adds the pause_events saturating counter port.
module tx_pause_ctrl
    import tx_pkg::*;
#(
    parameter int QUANTA_W          = DEFAULT_QUANTA_W,
    parameter int CYCLES_PER_QUANTA = cycles_per_quanta(64)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pause_load,
    input  logic [QUANTA_W-1:0] pause_quanta,
    input  logic                tx_req,
    input  logic                tx_done,
    output logic                tx_grant,
    output logic                pause_active,
    output logic [QUANTA_W-1:0] quanta_remaining
`ifdef TX_PAUSE_STATS_EN
    ,
    output logic [31:0]         pause_events
`endif
);

    tx_state_e           r_state;
    logic [QUANTA_W-1:0] r_quanta;
    logic                r_tx_grant;
    logic                r_pause_active;

    tx_state_e           w_next_state;
    logic [QUANTA_W-1:0] w_next_quanta;
    logic                w_psc_clear;
    logic                w_psc_enable;
    logic                w_wrap;
    logic                w_load_nz;

    assign w_load_nz = pause_load && (pause_quanta != '0);

    quanta_prescaler #(
        .CYCLES_PER_QUANTA(CYCLES_PER_QUANTA)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_psc_clear),
        .i_enable(w_psc_enable),
        .o_wrap  (w_wrap)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_quanta = r_quanta;
        w_psc_clear   = 1'b1;
        w_psc_enable  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load_nz) begin
                    w_next_state  = ST_PAUSED;
                    w_next_quanta = pause_quanta;
                end else if (tx_req) begin
                    w_next_state = ST_XMIT;
                end
            end
            ST_XMIT: begin
                if (pause_load) begin
                    w_next_quanta = pause_quanta;
                end
                if (tx_done) begin
                    w_next_state = (w_next_quanta != '0) ? ST_PAUSED : ST_IDLE;
                end
            end
            ST_PAUSED: begin
                w_psc_enable = 1'b1;
                w_psc_clear  = pause_load;
                if (pause_load) begin
                    w_next_quanta = pause_quanta;
                    if (pause_quanta == '0) begin
                        w_next_state = ST_IDLE;
                    end
                end else if (w_wrap && (r_quanta != '0)) begin
                    w_next_quanta = r_quanta - QUANTA_W'(1);
                    if (r_quanta == QUANTA_W'(1)) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_next_quanta = '0;
            end
        endcase
    end

    // NOTE: grant/active are flopped from the next-state decode so the ports come straight off flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_quanta       <= '0;
            r_tx_grant     <= 1'b0;
            r_pause_active <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_quanta       <= w_next_quanta;
            r_tx_grant     <= (w_next_state == ST_XMIT);
            r_pause_active <= (w_next_state == ST_PAUSED);
        end
    end

    assign tx_grant         = r_tx_grant;
    assign pause_active     = r_pause_active;
    assign quanta_remaining = r_quanta;

`ifdef TX_PAUSE_STATS_EN
    logic [31:0] r_pause_events;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pause_events <= '0;
        end else if (w_load_nz && (r_pause_events != '1)) begin
            r_pause_events <= r_pause_events + 32'd1;
        end
    end

    assign pause_events = r_pause_events;
`endif

endmodule

// File: doc/tx_pause_ctrl.md
# tx_pause_ctrl

Transmit-side 802.3x PAUSE enforcement for the 10G MAC tx_engine. Takes pause quanta decoded by the receive path, gates frame-start grants to the transmit datapath, and counts the quanta down in units of 512 bit times (8 clocks at 64-bit/156.25 MHz). A pause never truncates a frame in flight; it takes effect at the next frame boundary.

## Interface
Parameters:
- QUANTA_W, 16, width of pause quanta field
- CYCLES_PER_QUANTA, 8, clocks per 512 bit times; power of two, ≥ 2

Ports:
- clk  in  1  transmit clock
- reset_n  in  1  asynchronous, active-low reset
- pause_load  in  1  one-cycle strobe, valid PAUSE frame received
- pause_quanta  in  QUANTA_W  quanta value, sampled when pause_load=1
- tx_req  in  1  tx_engine requests to start a frame (level)
- tx_done  in  1  one-cycle strobe, last word of current frame sent
- tx_grant  out  1  frame start permitted; held high for the whole frame
- pause_active  out  1  high while in PAUSED
- quanta_remaining  out  QUANTA_W  current pause count
- pause_events  out  32  only with TX_PAUSE_STATS_EN (see Configuration)

## Operation
- States: IDLE, XMIT, PAUSED. Reset: IDLE, all outputs 0, prescaler 0.
- IDLE:
  - pause_load with quanta≠0 → PAUSED, quanta_remaining=quanta, prescaler=0.
  - Otherwise tx_req → XMIT.
  - pause_load with quanta=0 is ignored.
  - If pause_load and tx_req are both high, pause wins.
- XMIT: tx_grant=1. pause_load stores quanta into quanta_remaining (0 clears it); no countdown. On tx_done: → PAUSED if quanta_remaining≠0, else IDLE.
- PAUSED:
  - tx_grant=0. Prescaler counts 0..CYCLES_PER_QUANTA-1 and wraps.
  - On wrap, quanta_remaining decrements; the decrement that reaches 0 → IDLE.
  - pause_load overwrites quanta_remaining and clears the prescaler.
  - A loaded value of 0 → IDLE next cycle.
  - tx_req is ignored until IDLE.
- Arithmetic: quanta_remaining never underflows. The prescaler is log2(CYCLES_PER_QUANTA) bits.
- tx_done outside XMIT is ignored.
- Reset mid-frame or mid-pause: immediate return to reset values. The stored pause is discarded.

## Timing
- All outputs are registered.
- pause_load at cycle t in IDLE: pause_active=1 and quanta_remaining=Q at t+1.
- A pause of Q quanta holds PAUSED for exactly Q×CYCLES_PER_QUANTA cycles. pause_active falls at cycle t+1+Q×CYCLES_PER_QUANTA.
- tx_req at t in IDLE (no load): tx_grant=1 at t+1.
- tx_done at t: tx_grant=0 at t+1.
- tx_done and pause_load in the same XMIT cycle: the new quanta is used for the following PAUSED.
- Minimum gap between frames is one IDLE cycle. This block adds no IFG; the tx_engine owns IFG.

## Configuration
- TX_PAUSE_STATS_EN defined:
  - pause_events port exists: a 32-bit saturating count of accepted pause_load strobes with quanta≠0, in any state.
  - Reset value is 0. The counter holds at 0xFFFF_FFFF.
- TX_PAUSE_STATS_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package tx_pkg holds:
  - state enum (IDLE/XMIT/PAUSED);
  - QUANTA_W default;
  - PAUSE_QUANTUM_BITS=512 constant.
- One sub-module, quanta_prescaler: clear input, enable input, wrap-strobe output, parameterised by CYCLES_PER_QUANTA.
- FSM and quanta counter live in the top.

## Test plan
- Idle pause: pause_load Q=3 in IDLE, tx_req high → tx_grant stays 0 for 24 cycles. tx_grant=1 on the cycle after pause_active falls.
- Mid-frame pause: grant frame, pause_load Q=2 at frame word 5, tx_done 10 cycles later → frame completes, then PAUSED exactly 16 cycles, quanta_remaining 2→1→0.
- Refresh: in PAUSED with quanta_remaining=1, pause_load Q=4 → prescaler cleared, 32 further paused cycles.
- Cancel: in PAUSED, pause_load Q=0 → IDLE next cycle; pending tx_req granted one cycle later.
- Collisions:
  - pause_load Q=1 and tx_req in the same IDLE cycle → PAUSED 8 cycles, then grant.
  - tx_done and pause_load Q=5 in the same cycle → PAUSED 40 cycles.
- Reset: assert reset_n low mid-PAUSED → all outputs 0 immediately. With TX_PAUSE_STATS_EN, three loads (Q=7, 0, 9) → pause_events=2.
